// File: rtl/oled_text_streamer.sv
// oled_text_streamer
// Captures a CHARS-character ASCII frame and streams it one byte at a time,
// character 0 (the most significant byte of text) first, into the OLED
// controller's sendData / sendDataValid / sendDone handshake. A one-deep
// pending buffer accepts a new frame while one is in flight. Optional
// NUL-terminated mode replaces the first NUL and everything after it with
// FILL_CHAR. An abort ends the current frame after the in-flight byte.
//
// Ports:
//   clock            system clock
//   reset            asynchronous, active-low reset
//   text             frame; character i = text[(CHARS-i)*8-1 -: 8]
//   text_valid       one-cycle pulse capturing text and term_mode
//   term_mode        0 = verbatim, 1 = NUL-terminated with FILL_CHAR padding
//   abort            one-cycle pulse; ends current frame, drops pending frame
//   send_data        byte offered to the controller
//   send_data_valid  byte valid toward the controller
//   send_done        controller acknowledge
//   busy             high whenever not idle
//   char_index       index of the byte currently offered
//   frame_done       one-cycle pulse after the last byte's acknowledge
//   overrun          one-cycle pulse when a pending frame is overwritten
module oled_text_streamer #(
    parameter int           CHARS     = 64,
    parameter logic [7:0]   FILL_CHAR = 8'h20,
    localparam int          IDX_W     = $clog2(CHARS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CHARS*8-1:0] text,
    input  logic               text_valid,
    input  logic               term_mode,
    input  logic               abort,
    output logic [7:0]         send_data,
    output logic               send_data_valid,
    input  logic               send_done,
    output logic               busy,
    output logic [IDX_W-1:0]   char_index,
    output logic               frame_done,
    output logic               overrun
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd1,
        SEND     = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CHARS*8-1:0]   frame_q, frame_d;
    logic                 fmode_q, fmode_d;
    logic [CHARS*8-1:0]   pbuf_q, pbuf_d;
    logic                 pmode_q, pmode_d;
    logic                 pend_q, pend_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 nul_seen_q, nul_seen_d;
    logic                 abort_q, abort_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fdone_q, fdone_d;
    logic                 ovr_q, ovr_d;

    logic [CHARS*8-1:0]   shifted;
    logic [7:0]           raw_char;
    logic                 fill;
    logic                 last_byte;
    logic                 aborted;

    // Shifting the frame left brings character idx to the top byte, which
    // keeps the select a constant part-select.
    assign shifted   = frame_q << {idx_q, 3'b000};
    assign raw_char  = shifted[CHARS*8-1 -: 8];
    assign fill      = fmode_q && (nul_seen_q || (raw_char == 8'h00));
    assign last_byte = (idx_q == IDX_W'(CHARS - 1));
    // An abort arriving on the acknowledge cycle counts as latched.
    assign aborted   = abort_q || abort;

    // State register and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            fmode_q    <= 1'b0;
            pbuf_q     <= '0;
            pmode_q    <= 1'b0;
            pend_q     <= 1'b0;
            idx_q      <= '0;
            nul_seen_q <= 1'b0;
            abort_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fdone_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            fmode_q    <= fmode_d;
            pbuf_q     <= pbuf_d;
            pmode_q    <= pmode_d;
            pend_q     <= pend_d;
            idx_q      <= idx_d;
            nul_seen_q <= nul_seen_d;
            abort_q    <= abort_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fdone_q    <= fdone_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pend_q || text_valid) state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (abort)           state_d = IDLE;
                else if (!send_done) state_d = SEND;
            end
            SEND: begin
                if (send_done) state_d = (aborted || last_byte) ? IDLE : WAIT_LOW;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        frame_d    = frame_q;
        fmode_d    = fmode_q;
        pbuf_d     = pbuf_q;
        pmode_d    = pmode_q;
        pend_d     = pend_q;
        idx_d      = idx_q;
        nul_seen_d = nul_seen_q;
        abort_d    = abort_q;
        data_d     = data_q;
        valid_d    = valid_q;
        fdone_d    = 1'b0;
        ovr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d      = '0;
                nul_seen_d = 1'b0;
                abort_d    = 1'b0;
                if (pend_q) begin
                    frame_d = pbuf_q;
                    fmode_d = pmode_q;
                    pend_d  = 1'b0;
                end else if (text_valid) begin
                    frame_d = text;
                    fmode_d = term_mode;
                end
            end
            WAIT_LOW: begin
                if (abort) begin
                    pend_d = 1'b0;
                end else if (!send_done) begin
                    data_d  = fill ? FILL_CHAR : raw_char;
                    valid_d = 1'b1;
                    if (fill) nul_seen_d = 1'b1;
                end
            end
            SEND: begin
                // The in-flight byte always completes; only the rest is dropped.
                if (abort) begin
                    abort_d = 1'b1;
                    pend_d  = 1'b0;
                end
                if (send_done) begin
                    valid_d = 1'b0;
                    if (aborted || last_byte) fdone_d = last_byte && !aborted;
                    else                      idx_d   = idx_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Evaluated after the abort clear, so a frame arriving with an abort
        // survives as the new pending frame, and a pending frame being moved
        // into the frame buffer this cycle does not count as overwritten.
        if (text_valid && !(state_q == IDLE && !pend_q)) begin
            ovr_d   = pend_d;
            pbuf_d  = text;
            pmode_d = term_mode;
            pend_d  = 1'b1;
        end
    end

    assign send_data       = data_q;
    assign send_data_valid = valid_q;
    assign busy            = (state_q != IDLE);
    assign char_index      = idx_q;
    assign frame_done      = fdone_q;
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_oled_text_streamer.sv
module tb_oled_text_streamer;

    localparam int CHARS = 4;
    localparam int IDX_W = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [CHARS*8-1:0] text = '0;
    logic               text_valid = 1'b0;
    logic               term_mode = 1'b0;
    logic               abort = 1'b0;
    logic [7:0]         send_data;
    logic               send_data_valid;
    logic               send_done;
    logic               busy;
    logic [IDX_W-1:0]   char_index;
    logic               frame_done;
    logic               overrun;

    // Controller model: raises done on the third cycle a byte is valid,
    // lowers it once valid drops. man_done replaces it when model_en=0.
    logic model_en   = 1'b1;
    logic man_done   = 1'b0;
    logic model_done = 1'b0;
    int   model_cnt  = 0;
    assign send_done = model_en ? model_done : man_done;

    int n_assert = 0;
    int n_fail   = 0;

    int         fd_cnt   = 0;
    int         ov_cnt   = 0;
    int         viol_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] seen_q[$];

    always #5 clock = ~clock;

    oled_text_streamer #(
        .CHARS     (CHARS),
        .FILL_CHAR (8'h20)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .text            (text),
        .text_valid      (text_valid),
        .term_mode       (term_mode),
        .abort           (abort),
        .send_data       (send_data),
        .send_data_valid (send_data_valid),
        .send_done       (send_done),
        .busy            (busy),
        .char_index      (char_index),
        .frame_done      (frame_done),
        .overrun         (overrun)
    );

    always @(posedge clock) begin
        #1;
        if (send_data_valid && !prev_valid) seen_q.push_back(send_data);
        if (prev_valid && !send_data_valid && !send_done) viol_cnt++;
        if (frame_done) fd_cnt++;
        if (overrun) ov_cnt++;
        prev_valid = send_data_valid;
        if (!model_en) begin
            model_done = 1'b0;
            model_cnt  = 0;
        end else if (send_data_valid && !model_done) begin
            model_cnt++;
            if (model_cnt == 3) begin
                model_done = 1'b1;
                model_cnt  = 0;
            end
        end else if (!send_data_valid) begin
            model_done = 1'b0;
        end
    end

    function automatic logic [7:0] get_byte(input int i);
        if (i < seen_q.size()) return seen_q[i];
        return 8'hxx;
    endfunction

    task automatic pulse_text(input logic [CHARS*8-1:0] t, input logic m);
        @(negedge clock);
        text       = t;
        term_mode  = m;
        text_valid = 1'b1;
        @(negedge clock);
        text_valid = 1'b0;
    endtask

    task automatic wait_fd(input int target, input string tag);
        int k = 0;
        while (fd_cnt < target && k < 400) begin
            @(negedge clock);
            k++;
        end
        n_assert++;
        if (fd_cnt < target) begin
            n_fail++;
            $display("FAIL %s_timeout: frame_done count %0d, required %0d", tag, fd_cnt, target);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_assert++;
        if (send_data !== 8'h00 || send_data_valid !== 1'b0 || busy !== 1'b0 ||
            char_index !== 2'd0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h valid=%b busy=%b idx=%0d fd=%b ov=%b, required all 0",
                     send_data, send_data_valid, busy, char_index, frame_done, overrun);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_assert++;
        if (busy !== 1'b0 || send_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b valid=%b, required 0 0", busy, send_data_valid);
        end
    endtask

    task automatic test_basic();
        int base = seen_q.size();
        int fd0  = fd_cnt;
        int v0   = viol_cnt;
        logic [7:0] exp [4];
        exp = '{8'h41, 8'h42, 8'h43, 8'h44};
        pulse_text(32'h41424344, 1'b0);
        n_assert++;
        if (send_data_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_first_cycle: valid=%b busy=%b, required 0 1", send_data_valid, busy);
        end
        @(negedge clock);
        n_assert++;
        if (send_data_valid !== 1'b1 || send_data !== 8'h41 || char_index !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_latency: valid=%b data=%h idx=%0d, required 1 41 0",
                     send_data_valid, send_data, char_index);
        end
        wait_fd(fd0 + 1, "basic");
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_after_done: busy=%b, required 0", busy);
        end
        repeat (3) @(negedge clock);
        n_assert++;
        if (fd_cnt - fd0 != 1) begin
            n_fail++;
            $display("FAIL basic_frame_done_count: got %0d, required 1", fd_cnt - fd0);
        end
        n_assert++;
        if (seen_q.size() - base != 4) begin
            n_fail++;
            $display("FAIL basic_byte_count: got %0d, required 4", seen_q.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (get_byte(base + i) !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got %h, required %h", i, get_byte(base + i), exp[i]);
            end
        end
        n_assert++;
        if (viol_cnt != v0) begin
            n_fail++;
            $display("FAIL basic_valid_drop: %0d drops without done, required 0", viol_cnt - v0);
        end
    endtask

    task automatic test_term_mode();
        int base = seen_q.size();
        int fd0  = fd_cnt;
        logic [7:0] exp [4];
        exp = '{8'h48, 8'h20, 8'h20, 8'h20};
        pulse_text({8'h48, 8'h00, 8'h49, 8'h4A}, 1'b1);
        wait_fd(fd0 + 1, "term");
        repeat (3) @(negedge clock);
        n_assert++;
        if (seen_q.size() - base != 4) begin
            n_fail++;
            $display("FAIL term_byte_count: got %0d, required 4", seen_q.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (get_byte(base + i) !== exp[i]) begin
                n_fail++;
                $display("FAIL term_byte%0d: got %h, required %h", i, get_byte(base + i), exp[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int base = seen_q.size();
        int fd0  = fd_cnt;
        int ov0  = ov_cnt;
        logic [7:0] exp [8];
        exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h31, 8'h32, 8'h33, 8'h34};
        pulse_text(32'h61626364, 1'b0);
        repeat (4) @(negedge clock);
        pulse_text(32'h5758595A, 1'b0);
        repeat (2) @(negedge clock);
        pulse_text(32'h31323334, 1'b0);
        wait_fd(fd0 + 2, "overrun");
        repeat (3) @(negedge clock);
        n_assert++;
        if (ov_cnt - ov0 != 1) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d, required 1", ov_cnt - ov0);
        end
        n_assert++;
        if (seen_q.size() - base != 8) begin
            n_fail++;
            $display("FAIL overrun_byte_count: got %0d, required 8", seen_q.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            n_assert++;
            if (get_byte(base + i) !== exp[i]) begin
                n_fail++;
                $display("FAIL overrun_byte%0d: got %h, required %h", i, get_byte(base + i), exp[i]);
            end
        end
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_abort();
        int base = seen_q.size();
        int fd0  = fd_cnt;
        int ov0  = ov_cnt;
        int v0   = viol_cnt;
        int k    = 0;
        pulse_text(32'h41424344, 1'b0);
        repeat (2) @(negedge clock);
        pulse_text(32'h5758595A, 1'b0);
        while (!(send_data_valid === 1'b1 && char_index === 2'd1) && k < 100) begin
            @(negedge clock);
            k++;
        end
        n_assert++;
        if (!(send_data_valid === 1'b1 && char_index === 2'd1)) begin
            n_fail++;
            $display("FAIL abort_reach_byte1: valid=%b idx=%0d, required 1 1", send_data_valid, char_index);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_assert++;
        if (send_data_valid !== 1'b1 || send_data !== 8'h42) begin
            n_fail++;
            $display("FAIL abort_valid_held: valid=%b data=%h, required 1 42", send_data_valid, send_data);
        end
        repeat (20) @(negedge clock);
        n_assert++;
        if (seen_q.size() - base != 2 || get_byte(base) !== 8'h41 || get_byte(base + 1) !== 8'h42) begin
            n_fail++;
            $display("FAIL abort_bytes: count %0d first %h second %h, required 2 41 42",
                     seen_q.size() - base, get_byte(base), get_byte(base + 1));
        end
        n_assert++;
        if (fd_cnt != fd0) begin
            n_fail++;
            $display("FAIL abort_no_frame_done: got %0d pulses, required 0", fd_cnt - fd0);
        end
        n_assert++;
        if (busy !== 1'b0 || send_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b valid=%b, required 0 0", busy, send_data_valid);
        end
        n_assert++;
        if (viol_cnt != v0 || ov_cnt != ov0) begin
            n_fail++;
            $display("FAIL abort_handshake: drops %0d overruns %0d, required 0 0", viol_cnt - v0, ov_cnt - ov0);
        end
    endtask

    task automatic test_done_high_and_reset();
        @(negedge clock);
        model_en = 1'b0;
        man_done = 1'b1;
        pulse_text(32'h50515253, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_assert++;
            if (send_data_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL done_high_wait%0d: valid=%b busy=%b, required 0 1", i, send_data_valid, busy);
            end
        end
        man_done = 1'b0;
        @(negedge clock);
        n_assert++;
        if (send_data_valid !== 1'b1 || send_data !== 8'h50 || char_index !== 2'd0) begin
            n_fail++;
            $display("FAIL done_high_release: valid=%b data=%h idx=%0d, required 1 50 0",
                     send_data_valid, send_data, char_index);
        end
        man_done = 1'b1;
        @(negedge clock);
        man_done = 1'b0;
        n_assert++;
        if (send_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_high_ack: valid=%b, required 0", send_data_valid);
        end
        @(negedge clock);
        n_assert++;
        if (send_data_valid !== 1'b1 || send_data !== 8'h51 || char_index !== 2'd1) begin
            n_fail++;
            $display("FAIL done_high_byte1: valid=%b data=%h idx=%0d, required 1 51 1",
                     send_data_valid, send_data, char_index);
        end
        // Asynchronous reset in the middle of the low clock phase.
        #2;
        reset = 1'b0;
        #1;
        n_assert++;
        if (send_data_valid !== 1'b0 || busy !== 1'b0 || char_index !== 2'd0 || send_data !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b busy=%b idx=%0d data=%h, required 0 0 0 00",
                     send_data_valid, busy, char_index, send_data);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        n_assert++;
        if (busy !== 1'b0 || send_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stays_idle: busy=%b valid=%b, required 0 0", busy, send_data_valid);
        end
        model_en = 1'b1;
    endtask

    task automatic test_after_reset();
        int base = seen_q.size();
        int fd0  = fd_cnt;
        logic [7:0] exp [4];
        exp = '{8'h45, 8'h46, 8'h47, 8'h48};
        pulse_text(32'h45464748, 1'b0);
        wait_fd(fd0 + 1, "after_reset");
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (get_byte(base + i) !== exp[i]) begin
                n_fail++;
                $display("FAIL after_reset_byte%0d: got %h, required %h", i, get_byte(base + i), exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_term_mode();
        test_overrun();
        test_abort();
        test_done_high_and_reset();
        test_after_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #90000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/oled_text_streamer.md
Name: oled_text_streamer

Overview:
- Parametrised successor to the fixed 64-character OLED byte sender.
- Captures a CHARS-character ASCII frame and streams it byte by byte, MSB character first, into the OLED controller's sendData/sendDataValid/sendDone handshake.
- Adds the following over the fixed sender:
  - configurable frame length;
  - optional NUL-terminated mode with fill padding;
  - a one-deep pending-frame buffer, so new frames are accepted while busy;
  - abort.
- Returns to idle after each frame instead of locking up.
- Sits between the decimal_to_ascii / text sources and the oledControl instance.

Parameters:
- CHARS, 64, characters per frame (>=2). IDX_W = $clog2(CHARS).
- FILL_CHAR, 8'h20, byte sent in place of characters at and after the first NUL when term_mode=1.

Ports:
- clock  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-low reset.
- text  input  CHARS*8  frame; character i = text[(CHARS-i)*8-1 -: 8], with i=0 sent first.
- text_valid  input  1  one-cycle pulse; captures text and term_mode.
- term_mode  input  1  0 = send all CHARS bytes verbatim; 1 = NUL-terminated with FILL_CHAR padding.
- abort  input  1  one-cycle pulse; terminates the current frame and drops any pending frame.
- send_data  output  8  byte to oledControl sendData.
- send_data_valid  output  1  to oledControl sendDataValid.
- send_done  input  1  from oledControl sendDone.
- busy  output  1  high whenever state != IDLE.
- char_index  output  IDX_W  index of the byte currently offered.
- frame_done  output  1  one-cycle pulse after the last byte's send_done.
- overrun  output  1  one-cycle pulse when a pending frame is overwritten.

Behaviour:
- Reset (reset=0, asynchronous) clears the following to 0 and sets state to IDLE:
  - all outputs;
  - frame buffer, pending buffer and pending flag;
  - index and the NUL-seen flag.
- Internal registers:
  - frame buffer (CHARS*8) plus frame mode bit;
  - pending buffer plus mode bit plus pend flag;
  - idx (IDX_W);
  - nul_seen.
- Capture rule: text_valid in IDLE with pend=0 loads the frame buffer directly.
- In all other states, text_valid loads the pending buffer and sets pend.
  - If pend was already 1, the pending buffer is overwritten (latest wins) and overrun pulses.
- IDLE:
  - If pend=1: move pending to frame, clear pend, go to WAIT_LOW.
  - Else if text_valid: capture and go to WAIT_LOW.
  - In both cases idx=0 and nul_seen=0.
- WAIT_LOW:
  - If abort: clear pend and go to IDLE; no byte is issued.
  - Else if send_done=0: load send_data with the byte, assert send_data_valid, go to SEND.
  - While send_done=1, stay in WAIT_LOW (the controller is still finishing the previous byte).
- Byte selection:
  - raw = char(idx).
  - If mode=1 and (nul_seen or raw==8'h00): send FILL_CHAR and set nul_seen.
  - Otherwise send raw.
- SEND:
  - Hold send_data and send_data_valid stable until send_done=1.
  - On send_done=1: send_data_valid <= 0.
    - If abort was latched, or idx==CHARS-1: go to IDLE. frame_done pulses only on a non-aborted last byte.
    - Else: idx <= idx+1 and go to WAIT_LOW.
- Abort in SEND:
  - Latched; the in-flight byte is allowed to complete (never drop valid before done).
  - pend is cleared immediately.
  - frame_done is not pulsed.
- Latency:
  - text_valid in IDLE → send_data_valid=1 two cycles later (IDLE→WAIT_LOW→SEND edge), given send_done=0.
  - Between bytes: at least 1 cycle with valid=0.
- Simultaneous events:
  - text_valid on the cycle of the last send_done goes to pending; the next frame starts from IDLE on the following cycle.
  - text_valid together with abort: abort clears the old pend first, then the new text is stored as pend. The new frame survives.
- char_index = idx. It is frame-relative and resets to 0 at each frame start.
- send_data holds its last value when idle; consumers qualify it with send_data_valid.

Test Plan:
- CHARS=4, text="ABCD", mode 0, oledControl model asserting send_done 3 cycles after valid → bytes 0x41,0x42,0x43,0x44 in order; valid drops each done; frame_done pulses once; busy falls the cycle after.
- CHARS=4, text={8'h48,8'h00,8'h49,8'h4A}, mode 1 → bytes 0x48,0x20,0x20,0x20 (the byte after the NUL is also filled).
- Second text_valid "WXYZ" mid-frame, then a third "1234" before the end → overrun pulses once; after frame_done the next frame sends "1234" only.
- abort asserted while byte 1 is valid → valid held until send_done; no further bytes; no frame_done; pending frame discarded; busy=0.
- send_done held high for 5 cycles after the previous ack when a new frame starts → module waits in WAIT_LOW; valid rises only on the first cycle after send_done=0.
- Assert reset low mid-SEND → send_data_valid, busy and char_index go to 0 immediately (asynchronously); after release the module stays idle until text_valid.
